// File: rtl/crc8_64_dec_pkg.sv
// Shared CRC-8 definitions for the 64-bit codeword encoder/decoder pair.
package crc8_pkg;

  localparam int CRC_W  = 8;
  localparam int DATA_W = 64;
  localparam int CODE_W = 72;
  localparam int NBYTES = 9;

  localparam logic [CRC_W-1:0] DEF_POLY = 8'h07;
  localparam logic [CRC_W-1:0] DEF_INIT = 8'h00;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // One byte through the CRC, MSB first, no reflection.
  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                 input logic [7:0]       data,
                                                 input logic [CRC_W-1:0] poly);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ data[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_64_dec_if.sv
// Codeword-in / checked-payload-out bundle for crc8_64_dec.
interface crc8_64_dec_if #(
  parameter int CNT_W = 16
);
  logic [0:crc8_pkg::CODE_W-1] i_code;
  logic                        i_valid;
  logic                        o_ready;
  logic [0:crc8_pkg::DATA_W-1] o_data;
  logic                        o_valid;
  logic                        o_err;
  logic [crc8_pkg::CRC_W-1:0]  o_syndrome;
  logic [CNT_W-1:0]            o_err_cnt;

  modport master (
    output i_code, i_valid,
    input  o_ready, o_data, o_valid, o_err, o_syndrome, o_err_cnt
  );

  modport slave (
    input  i_code, i_valid,
    output o_ready, o_data, o_valid, o_err, o_syndrome, o_err_cnt
  );
endinterface

// File: rtl/crc8_64_dec_byte_step.sv
// Combinational single-byte CRC-8 update used by the decoder datapath.
module crc8_byte_step
  import crc8_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = DEF_POLY
) (
  input  logic [CRC_W-1:0] i_crc,
  input  logic [7:0]       i_byte,
  output logic [CRC_W-1:0] o_crc
);
  assign o_crc = crc8_step(i_crc, i_byte, POLY);
endmodule

// File: rtl/crc8_64_dec.sv
// CRC-8 checker for 72-bit codewords: recomputes the CRC one byte per cycle
// and reports payload, syndrome, error flag and a saturating error count.
module crc8_64_dec
  import crc8_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY  = DEF_POLY,
  parameter logic [CRC_W-1:0] INIT  = DEF_INIT,
  parameter int               CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  crc8_64_dec_if.slave bus
);

  state_t             r_state;
  state_t             w_next;
  logic [0:CODE_W-1]  r_code;
  logic [CRC_W-1:0]   r_crc;
  logic [CRC_W-1:0]   w_crc_next;
  logic [3:0]         r_byte_cnt;
  logic [0:DATA_W-1]  r_data;
  logic [CRC_W-1:0]   r_syndrome;
  logic               r_err;
  logic [CNT_W-1:0]   r_err_cnt;
  logic [7:0]         w_bytes [NBYTES];
  logic [7:0]         w_byte;
  logic               w_last;

  for (genvar k = 0; k < NBYTES; k++) begin : g_bytes
    assign w_bytes[k] = r_code[8*k +: 8];
  end

  assign w_byte = w_bytes[r_byte_cnt];
  assign w_last = (r_byte_cnt == 4'(NBYTES - 1));

  crc8_byte_step #(.POLY(POLY)) u_step (
    .i_crc  (r_crc),
    .i_byte (w_byte),
    .o_crc  (w_crc_next)
  );

  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // NOTE: w_next gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.i_valid)       w_next = CALC;
      CALC:    if (enable && w_last)  w_next = DONE;
      DONE:                           w_next = IDLE;
      default:                        w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.o_ready    = (r_state == IDLE);
    bus.o_valid    = (r_state == DONE);
    bus.o_data     = r_data;
    bus.o_err      = r_err;
    bus.o_syndrome = r_syndrome;
    bus.o_err_cnt  = r_err_cnt;
  end

  // NOTE: the capture register is reset as well so a discarded word never leaks X.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_code     <= '0;
      r_crc      <= INIT;
      r_byte_cnt <= '0;
      r_data     <= '0;
      r_syndrome <= '0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.i_valid) begin
          r_code     <= bus.i_code;
          r_crc      <= INIT;
          r_byte_cnt <= '0;
        end
        CALC: if (enable) begin
          r_crc      <= w_crc_next;
          r_byte_cnt <= r_byte_cnt + 4'd1;
          // Results are latched on the last byte and held until the next word.
          if (w_last) begin
            r_data     <= r_code[0:DATA_W-1];
            r_syndrome <= w_crc_next;
            r_err      <= |w_crc_next;
          end
        end
        DONE: if (r_err && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc8_64_dec.sv
// Scoreboard bench for crc8_64_dec: latency, syndrome, error count, stall,
// backpressure, reset mid-word and counter saturation.
module tb_crc8_64_dec;
  import crc8_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc8_64_dec_if #(.CNT_W(16)) bus ();
  crc8_64_dec_if #(.CNT_W(2))  bus_s ();

  crc8_64_dec #(.POLY(8'h07), .INIT(8'h00), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus)
  );

  crc8_64_dec #(.POLY(8'h07), .INIT(8'h00), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus_s)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-serial reference over the first n bits, bit 0 first.
  function automatic logic [7:0] ref_crc(input logic [0:71] bits, input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n; i++)
      c = (c[7] ^ bits[i]) ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
  endfunction

  function automatic logic [0:71] make_code(input logic [63:0] data);
    logic [0:71] code;
    code = {data, 8'h00};
    code[64:71] = ref_crc(code, 64);
    return code;
  endfunction

  typedef struct {
    logic [63:0] data;
    logic [7:0]  syn;
    logic        err;
    logic [15:0] cnt_before;
    logic [15:0] cnt_after;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   model_cnt = 0;

  // The strobe follows edge E9 after the accept edge E0, plus one per stall.
  localparam int LAT_EDGES = 9;

  task automatic send(input logic [0:71] code, input int lat, input bit expect_out,
                      output int acc);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    bus.i_code  = code;
    bus.i_valid = 1'b1;
    while (!bus.o_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", 64'(waited < 50), 64'd1);
    acc = cyc + 1;
    if (expect_out) begin
      e.data       = code[0:63];
      e.syn        = ref_crc(code, 72);
      e.err        = (e.syn != 8'h00);
      e.cnt_before = 16'(model_cnt);
      if (e.err && model_cnt != 16'hFFFF) model_cnt++;
      e.cnt_after  = 16'(model_cnt);
      e.acc        = acc;
      e.lat        = lat;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.o_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(bus.o_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("latency",    64'(cyc - mon_e.acc), 64'(mon_e.lat));
        check("data",       bus.o_data,            mon_e.data);
        check("syndrome",   64'(bus.o_syndrome),   64'(mon_e.syn));
        check("err",        64'(bus.o_err),        64'(mon_e.err));
        check("cnt_during", 64'(bus.o_err_cnt),    64'(mon_e.cnt_before));
        @(negedge clk);
        check("valid_pulse", 64'(bus.o_valid),     64'd0);
        check("cnt_after",   64'(bus.o_err_cnt),   64'(mon_e.cnt_after));
        check("data_hold",   bus.o_data,           mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int a1, a2, idle_bad, waited;
    logic [1:0] sat_exp;

    // Reset held together with a valid word: nothing may be captured.
    reset         = 1'b1;
    enable        = 1'b1;
    bus.i_code    = make_code(64'hDEAD_BEEF_0000_1111);
    bus.i_valid   = 1'b1;
    bus_s.i_code  = '0;
    bus_s.i_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset       = 1'b0;
    bus.i_valid = 1'b0;

    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.o_ready || bus.o_valid) idle_bad++;
    end
    check("idle_ready_valid", 64'(idle_bad),        64'd0);
    check("rst_data",         bus.o_data,           64'd0);
    check("rst_syndrome",     64'(bus.o_syndrome),  64'd0);
    check("rst_err",          64'(bus.o_err),       64'd0);
    check("rst_err_cnt",      64'(bus.o_err_cnt),   64'd0);

    // Clean words.
    send(72'h00_0000_0000_0000_0107, LAT_EDGES, 1'b1, a1);
    repeat (12) @(negedge clk);
    send(72'h00_0000_0000_0000_020E, LAT_EDGES, 1'b1, a1);
    repeat (12) @(negedge clk);
    send(make_code(64'h0123_4567_89AB_CDEF), LAT_EDGES, 1'b1, a1);
    repeat (12) @(negedge clk);

    // Bit 71 flipped: the syndrome becomes step(0, 8'h01) = POLY.
    send(72'h00_0000_0000_0000_0106, LAT_EDGES, 1'b1, a1);
    repeat (12) @(negedge clk);
    check("syn_single_bit", 64'(bus.o_syndrome), 64'h07);
    check("cnt_single_bit", 64'(bus.o_err_cnt),  64'd1);

    // Three-cycle enable stall in CALC.
    send(make_code(64'hFEDC_BA98_7654_3210), LAT_EDGES + 3, 1'b1, a1);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (10) @(negedge clk);

    // Second word waits with i_valid high until the first IDLE cycle.
    send(make_code(64'h5555_AAAA_5555_AAAA), LAT_EDGES, 1'b1, a1);
    send(72'h80_0000_0000_0000_0107, LAT_EDGES, 1'b1, a2);
    check("bp_accept_gap", 64'(a2 - a1), 64'd11);
    repeat (12) @(negedge clk);

    // Reset four cycles after accepting an erroneous word.
    send(72'h00_0000_0000_0000_0106, 0, 1'b0, a1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    model_cnt = 0;
    check("midrst_ready",   64'(bus.o_ready),     64'd1);
    check("midrst_valid",   64'(bus.o_valid),     64'd0);
    check("midrst_err_cnt", 64'(bus.o_err_cnt),   64'd0);
    check("midrst_syn",     64'(bus.o_syndrome),  64'd0);
    repeat (14) @(negedge clk);

    send(make_code(64'h0000_0000_CAFE_F00D), LAT_EDGES, 1'b1, a1);
    repeat (12) @(negedge clk);

    // Saturating 2-bit counter on the second instance.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus_s.i_code  = 72'h00_0000_0000_0000_0106;
      bus_s.i_valid = 1'b1;
      waited = 0;
      while (!bus_s.o_ready && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      @(negedge clk);
      bus_s.i_valid = 1'b0;
      waited = 0;
      while (!bus_s.o_valid && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      check("sat_valid", 64'(bus_s.o_valid), 64'd1);
      check("sat_err",   64'(bus_s.o_err),   64'd1);
      @(negedge clk);
      sat_exp = (k < 3) ? 2'(k + 1) : 2'd3;
      check("sat_cnt", 64'(bus_s.o_err_cnt), 64'(sat_exp));
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
